pe_sched: RTL and testbench

PE_SCHED -- requirements
Module: pe_sched

---
 rtl/pe_sched_pkg.sv | 28 ++
 rtl/pe_sched.sv | 152 +++++++++++++++
 tb/tb_pe_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_sched_pkg.sv
// Shared widths, beat counts and FSM state encoding for the PE row scheduler.
package pe_sched_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned INPUT_SIZE = 28;
  localparam int unsigned PSUM_W     = 2 * DATA_WIDTH + 2;
  localparam int unsigned ACC_W      = PSUM_W + 4;
  localparam int unsigned BEATS_L0   = 26;
  localparam int unsigned BEATS_L1   = 10;
  localparam int unsigned MAX_ROWS   = 28;
  localparam int unsigned WDOG_MAX   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLaunch,
    StWait,
    StStream,
    StSum,
    StGap,
    StDone
  } state_e;

  function automatic logic [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
    return {{(ACC_W - PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/pe_sched.sv
// Row scheduler: fetches rows, launches the PE, streams (layer 0) or sums (layer 1) its beats.
module pe_sched
  import pe_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              layer_cfg_i,
  input  logic [5:0]        num_rows_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              row_req_o,
  input  logic              row_ack_i,
  output logic [4:0]        row_idx_o,
  output logic              pe_enable_o,
  output logic              pe_layer_o,
  input  logic [PSUM_W-1:0] pe_psum_i,
  input  logic              pe_flag_comp_i,
  output logic              out_valid_o,
  output logic [ACC_W-1:0]  out_data_o,
  output logic              out_last_o
);

  state_e           state_q;
  logic             busy_q, done_q, err_q, row_req_q, pe_enable_q, layer_q;
  logic [4:0]       rows_q, row_idx_q, beat_q;
  logic [2:0]       wdog_q;
  logic [ACC_W-1:0] acc_q;

  logic [4:0]       rows_in, beat_inc, beats_exp;
  logic [ACC_W-1:0] acc_sum;
  logic             beat_fire, last_row, sum_out, l0_out;

  always_comb begin
    rows_in   = (num_rows_i > 6'(MAX_ROWS)) ? 5'(MAX_ROWS) : num_rows_i[4:0];
    // Saturate so an overlong row cannot wrap back onto the nominal count.
    beat_inc  = (beat_q == 5'h1f) ? beat_q : beat_q + 5'd1;
    beats_exp = layer_q ? 5'(BEATS_L1) : 5'(BEATS_L0);
    acc_sum   = acc_q + sext_psum(pe_psum_i);
    beat_fire = pe_flag_comp_i && (state_q == StWait || state_q == StStream);
    last_row  = (row_idx_q == rows_q - 5'd1);
    sum_out   = (state_q == StSum);
    l0_out    = beat_fire && !layer_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      row_req_q   <= 1'b0;
      pe_enable_q <= 1'b0;
      layer_q     <= 1'b0;
      rows_q      <= '0;
      row_idx_q   <= '0;
      beat_q      <= '0;
      wdog_q      <= '0;
      acc_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      pe_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            layer_q   <= layer_cfg_i;
            rows_q    <= rows_in;
            row_idx_q <= '0;
            if (rows_in == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              row_req_q <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (row_ack_i) begin
            // Per-row counters and the accumulator start fresh as the PE launches.
            row_req_q   <= 1'b0;
            pe_enable_q <= 1'b1;
            acc_q       <= '0;
            beat_q      <= '0;
            wdog_q      <= '0;
            state_q     <= StLaunch;
          end
        end
        StLaunch: state_q <= StWait;
        StWait: begin
          if (pe_flag_comp_i) begin
            beat_q  <= beat_inc;
            acc_q   <= acc_sum;
            state_q <= StStream;
          end else if (wdog_q == 3'(WDOG_MAX - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            wdog_q <= wdog_q + 3'd1;
          end
        end
        StStream: begin
          if (pe_flag_comp_i) begin
            beat_q <= beat_inc;
            acc_q  <= acc_sum;
          end else begin
            if (beat_q != beats_exp) err_q <= 1'b1;
            state_q <= layer_q ? StSum : StGap;
          end
        end
        StSum: state_q <= StGap;
        StGap: begin
          if (last_row) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            row_idx_q <= row_idx_q + 5'd1;
            row_req_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy_o      = busy_q;
    done_o      = done_q;
    err_o       = err_q;
    row_req_o   = row_req_q;
    row_idx_o   = row_idx_q;
    pe_enable_o = pe_enable_q;
    pe_layer_o  = layer_q;
    out_valid_o = l0_out || sum_out;
    out_data_o  = '0;
    if (sum_out) begin
      out_data_o = acc_q;
    end else if (l0_out) begin
      out_data_o = sext_psum(pe_psum_i);
    end
    out_last_o  = last_row && (sum_out || (l0_out && beat_q == 5'(BEATS_L0 - 1)));
  end

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: PE/row-buffer responders, a queue-based output model, literal pins.
module tb_pe_sched;
  import pe_sched_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              layer_cfg_i = 1'b0;
  logic [5:0]        num_rows_i = '0;
  logic              row_ack_i = 1'b0;
  logic [PSUM_W-1:0] pe_psum_i = '0;
  logic              pe_flag_comp_i = 1'b0;
  logic              busy_o, done_o, err_o, row_req_o, pe_enable_o, pe_layer_o;
  logic [4:0]        row_idx_o;
  logic              out_valid_o, out_last_o;
  logic [ACC_W-1:0]  out_data_o;

  always #5 clk_i = ~clk_i;

  pe_sched dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .layer_cfg_i    (layer_cfg_i),
    .num_rows_i     (num_rows_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .row_req_o      (row_req_o),
    .row_ack_i      (row_ack_i),
    .row_idx_o      (row_idx_o),
    .pe_enable_o    (pe_enable_o),
    .pe_layer_o     (pe_layer_o),
    .pe_psum_i      (pe_psum_i),
    .pe_flag_comp_i (pe_flag_comp_i),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o)
  );

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0, failures = 0;
  int               pe_beats = 26, pe_lat = 1, pe_mode = 0;
  int               n_valid = 0, n_done = 0, n_req = 0;
  int               cyc = 0, en_cyc = 0, done_cyc = 0, waited = 0;
  logic [ACC_W-1:0] last_data = '0;

  function automatic int psum_val(input int mode, input int r, input int k);
    case (mode)
      0:       return r * 100 + k - 13;
      1:       return k + 1;
      2:       return -3;
      default: return -131072;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Expected output stream of a whole job, straight from the layer rules.
  task automatic build_exp(input bit layer, input int rows, input int beats, input int mode);
    exp_t e;
    int   s;
    exp_q.delete();
    if (beats == 0) return;
    for (int r = 0; r < rows; r++) begin
      if (!layer) begin
        for (int k = 0; k < beats; k++) begin
          e.data = ACC_W'(psum_val(mode, r, k));
          e.last = (r == rows - 1) && (k == beats - 1);
          exp_q.push_back(e);
        end
      end else begin
        s = 0;
        for (int k = 0; k < beats; k++) s += psum_val(mode, r, k);
        e.data = ACC_W'(s);
        e.last = (r == rows - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Row buffer: acknowledge one cycle after each request.
  initial forever begin
    @(posedge clk_i);
    #1;
    row_ack_i = row_req_o && !row_ack_i;
  end

  // PE: after enable, wait pe_lat cycles then present pe_beats consecutive beats.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (pe_enable_o) begin
      int row;
      row = int'(row_idx_o);
      repeat (pe_lat) begin
        @(posedge clk_i);
        #1;
      end
      for (int k = 0; k < pe_beats; k++) begin
        pe_psum_i      = PSUM_W'(psum_val(pe_mode, row, k));
        pe_flag_comp_i = 1'b1;
        @(posedge clk_i);
        #1;
      end
      pe_flag_comp_i = 1'b0;
      pe_psum_i      = '0;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (out_valid_o) begin
      exp_t e;
      n_valid++;
      last_data = out_data_o;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got data %0h want no output", out_data_o);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data_o), 64'(e.data));
        check("out_last", 64'(out_last_o), 64'(e.last));
      end
    end else begin
      check("out_last_idle", 64'(out_last_o), 64'(0));
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (row_req_o) n_req++;
    if (pe_enable_o) en_cyc = cyc;
  end

  task automatic run_job(input string name, input bit layer, input int nrows, input int beats,
                         input int mode, input int lat, input bit poke);
    int rows, nom;
    bit exp_err;
    rows     = (nrows > int'(MAX_ROWS)) ? int'(MAX_ROWS) : nrows;
    nom      = layer ? int'(BEATS_L1) : int'(BEATS_L0);
    exp_err  = (rows > 0) && (beats != nom);
    pe_beats = beats;
    pe_mode  = mode;
    pe_lat   = lat;
    build_exp(layer, rows, beats, mode);
    n_valid  = 0;
    n_done   = 0;
    n_req    = 0;
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    layer_cfg_i = layer;
    num_rows_i  = nrows[5:0];
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    layer_cfg_i = ~layer;
    num_rows_i  = 6'd3;
    if (rows > 0) begin
      check({name, " busy"}, 64'(busy_o), 64'(1));
      check({name, " err_clear"}, 64'(err_o), 64'(0));
      check({name, " pe_layer"}, 64'(pe_layer_o), 64'(layer));
    end
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
      start_i = poke && (waited == 6);
    end while (!done_o && waited < 4000);
    start_i = 1'b0;
    check({name, " done_seen"}, 64'(done_o), 64'(1));
    if (rows == 0) check({name, " done_latency"}, 64'(waited), 64'(1));
    @(negedge clk_i);
    check({name, " done_pulse"}, 64'(done_o), 64'(0));
    check({name, " idle_busy"}, 64'(busy_o), 64'(0));
    check({name, " err"}, 64'(err_o), 64'(exp_err));
    check({name, " done_count"}, 64'(n_done), 64'(1));
    check({name, " outputs_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int cnt, snap;
    #3;
    check("reset_outputs", 64'({busy_o, done_o, err_o, row_req_o, pe_enable_o, pe_layer_o,
                                out_valid_o, out_last_o, row_idx_o, out_data_o}), 64'(0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    run_job("l0_two_rows", 1'b0, 2, 26, 0, 1, 1'b0);
    check("l0_beat_count", 64'(n_valid), 64'(52));

    run_job("l1_ramp", 1'b1, 1, 10, 1, 1, 1'b0);
    check("l1_ramp_sum", 64'(last_data), 64'(55));
    check("l1_ramp_count", 64'(n_valid), 64'(1));

    run_job("l1_neg", 1'b1, 1, 10, 2, 1, 1'b0);
    check("l1_neg_sum", 64'(last_data), 64'(22'h3FFFE2));

    run_job("empty", 1'b0, 0, 26, 0, 1, 1'b0);
    check("empty_no_valid", 64'(n_valid), 64'(0));
    check("empty_no_req", 64'(n_req), 64'(0));

    run_job("wdog", 1'b0, 2, 0, 0, 1, 1'b0);
    check("wdog_latency", 64'(done_cyc - en_cyc), 64'(5));
    check("wdog_no_valid", 64'(n_valid), 64'(0));

    run_job("after_wdog_lat4", 1'b1, 3, 10, 0, 4, 1'b1);

    run_job("short_row", 1'b1, 2, 9, 1, 1, 1'b0);
    check("short_row_sum", 64'(last_data), 64'(45));

    run_job("clamp", 1'b1, 40, 10, 1, 1, 1'b0);
    check("clamp_rows", 64'(n_valid), 64'(28));

    run_job("l0_min", 1'b0, 1, 26, 3, 2, 1'b1);
    check("l0_min_data", 64'(last_data), 64'(22'h3E0000));

    // Reset in the middle of row 1's stream.
    pe_beats = 26;
    pe_mode  = 0;
    pe_lat   = 1;
    build_exp(1'b0, 3, 26, 0);
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    layer_cfg_i = 1'b0;
    num_rows_i  = 6'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cnt     = 0;
    waited  = 0;
    do begin
      @(negedge clk_i);
      waited++;
      if (out_valid_o && row_idx_o == 5'd1) cnt++;
    end while (cnt < 3 && waited < 2000);
    check("rst_reached_stream", 64'(cnt), 64'(3));
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({busy_o, done_o, err_o, row_req_o, pe_enable_o, out_valid_o,
                                  out_last_o, row_idx_o}), 64'(0));
    exp_q.delete();
    snap = n_done;
    repeat (40) @(negedge clk_i);
    check("rst_no_done", 64'(n_done - snap), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_job("post_reset", 1'b0, 2, 26, 0, 1, 1'b0);
    check("post_reset_count", 64'(n_valid), 64'(52));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
